// File: rtl/fir_pkg.sv
// fir_pkg: shared types for the systolic FIR front end
//  DATA_W : sample width
//  pair_t : {x, d} sample pair as buffered by the feeder
//  state_t: feeder FSM states
package fir_pkg;
   localparam int DATA_W = 32;
   typedef struct packed {
      logic signed [DATA_W-1:0] x;
      logic signed [DATA_W-1:0] d;
   } pair_t;
   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy output, no write-to-read bypass
//  clk, rst      : clock, synchronous active-high reset
//  push, wdata   : write request (ignored while full) and data
//  pop, rdata    : read request (ignored while empty); rdata shows the head entry
//  level         : occupancy 0..DEPTH
//  full, empty   : derived from level, not from pointer comparison
module sync_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full    = level == FULL_LVL;
   assign empty   = level == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rp];
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= wdata;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/sample_feeder.sv
// sample_feeder: buffers (x, d) pairs and issues one per cycle to the FIR array, d delayed by D_DLY issues
//  clk, rst                 : clock, synchronous active-high reset
//  run                      : 1 = stream, 0 = stop after the current cycle
//  in_valid/in_ready/in_x/in_d : sample pair input; in_ready = !full
//  pe_valid/pe_x/pe_d       : issue slot to the first process_element
//  level                    : FIFO occupancy
//  underflow                : sticky, FIFO empty while streaming
//  ZERO_FILL_EN (define)    : empty FIFO in RUN issues zero samples instead of a bubble
module sample_feeder
   import fir_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PRIME = 4,
   parameter int D_DLY = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_x,
   input  logic signed [DATA_W-1:0] in_d,
   output logic                     pe_valid,
   output logic signed [DATA_W-1:0] pe_x,
   output logic signed [DATA_W-1:0] pe_d,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     underflow
);
   localparam logic [$clog2(DEPTH):0] PRIME_LVL = ($clog2(DEPTH)+1)'(PRIME);
   state_t st, st_nx;
   pair_t wr, rd;
   logic full, empty, pop, issue;
   logic signed [DATA_W-1:0] iss_x, iss_d;
   logic signed [DATA_W-1:0] dly [D_DLY];
   assign wr = {in_x, in_d};
   sync_fifo #(.W(2*DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (pop),
      .wdata (wr),
      .rdata (rd),
      .level (level),
      .full  (full),
      .empty (empty)
   );
   always_ff @(posedge clk)
      st <= rst ? IDLE : st_nx;
   // dropping run returns to IDLE from any state
   always_comb
      st_nx = !run ? IDLE : st == IDLE ? FILL : (st == FILL && level >= PRIME_LVL) ? RUN : st;
   // gating pop with run suppresses the pop in the cycle run falls
   always_comb begin
      pop      = st == RUN && run && !empty;
`ifdef ZERO_FILL_EN
      issue    = st == RUN && run;
`else
      issue    = pop;
`endif
      iss_x    = pop ? rd.x : '0;
      iss_d    = pop ? rd.d : '0;
      in_ready = !full;
   end
   // the delay line only shifts on issue slots so d stays aligned with the array cadence
   always_ff @(posedge clk) begin
      if (rst) begin
         pe_valid  <= 1'b0;
         pe_x      <= '0;
         pe_d      <= '0;
         underflow <= 1'b0;
         for (int i = 0; i < D_DLY; i++) dly[i] <= '0;
      end else begin
         pe_valid <= issue;
         if (issue) begin
            pe_x   <= iss_x;
            pe_d   <= dly[D_DLY-1];
            dly[0] <= iss_d;
            for (int i = 1; i < D_DLY; i++) dly[i] <= dly[i-1];
         end
         if (st == RUN && run && empty) underflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sample_feeder.sv
// tb_sample_feeder: randomized self-checking bench for sample_feeder against a queue-based model
module tb_sample_feeder;
   import fir_pkg::*;
   localparam int DEPTH = 16;
   localparam int PRIME = 2;
   localparam int D_DLY = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0, rst = 1'b1, run = 1'b0, in_valid = 1'b0;
   logic signed [DATA_W-1:0] in_x = '0, in_d = '0;
   logic in_ready, pe_valid, underflow;
   logic signed [DATA_W-1:0] pe_x, pe_d;
   logic [LW-1:0] level;

   sample_feeder #(.DEPTH(DEPTH), .PRIME(PRIME), .D_DLY(D_DLY)) dut (
      .clk(clk), .rst(rst), .run(run), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_d(in_d), .pe_valid(pe_valid), .pe_x(pe_x), .pe_d(pe_d),
      .level(level), .underflow(underflow)
   );

   always #5 clk = ~clk;

   pair_t m_q[$];
   logic signed [DATA_W-1:0] hist[$];
   state_t m_st = IDLE;
   logic m_valid = 1'b0, m_uf = 1'b0, m_push = 1'b0, m_rdy = 1'b1;
   logic signed [DATA_W-1:0] m_x = '0, m_d = '0;
   logic [LW-1:0] m_lvl = '0;
   int errors = 0, checks = 0;

   // one clock: the model applies the current inputs to its pre-edge state, then outputs settle
   task automatic cycle();
      int sz;
      logic pop, iss;
      pair_t p, w;
      sz  = m_q.size();
      pop = m_st == RUN && run && sz > 0;
`ifdef ZERO_FILL_EN
      iss = m_st == RUN && run;
`else
      iss = pop;
`endif
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         hist.delete();
         m_st = IDLE; m_valid = 0; m_x = '0; m_d = '0; m_uf = 0; m_push = 0;
      end else begin
         if (m_st == RUN && run && sz == 0) m_uf = 1;
         if (!run) m_st = IDLE;
         else if (m_st == IDLE) m_st = FILL;
         else if (m_st == FILL && sz >= PRIME) m_st = RUN;
         p = '0;
         if (pop) p = m_q.pop_front();
         m_push = in_valid && sz < DEPTH;
         if (m_push) begin
            w.x = in_x; w.d = in_d;
            m_q.push_back(w);
         end
         m_valid = iss;
         if (iss) begin
            m_x = p.x;
            hist.push_back(p.d);
            m_d = hist.size() > D_DLY ? hist[hist.size()-1-D_DLY] : '0;
         end
      end
      m_lvl = LW'(m_q.size());
      m_rdy = m_q.size() < DEPTH;
      #1;
   endtask

   task automatic test_reset();
      rst = 1; cycle(); cycle();
      checks++;
      if ({in_ready, pe_valid, level, underflow, pe_x, pe_d} !== {1'b1, 1'b0, LW'(0), 1'b0, 32'sd0, 32'sd0}) begin
         errors++;
         $display("FAIL reset: rdy=%0b v=%0b lvl=%0d uf=%0b x=%0d d=%0d, want 1 0 0 0 0 0", in_ready, pe_valid, level, underflow, pe_x, pe_d);
      end
      rst = 0;
   endtask

   task automatic test_prime();
      run = 1; in_valid = 1; in_x = -150; in_d = 69;
      cycle();
      in_x = 22; in_d = 5;
      cycle();
      in_valid = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if ({pe_valid, pe_x, pe_d, level, in_ready, underflow} !== {m_valid, m_x, m_d, m_lvl, m_rdy, m_uf}) begin
            errors++;
            $display("FAIL prime model i=%0d: dut=%h want=%h", i, {pe_valid, pe_x, pe_d, level, in_ready, underflow}, {m_valid, m_x, m_d, m_lvl, m_rdy, m_uf});
         end
         if (i > 0) begin
            checks++;
            if (pe_valid !== 1'b1 || pe_x !== (i == 1 ? -32'sd150 : 32'sd22) || pe_d !== 32'sd0) begin
               errors++;
               $display("FAIL prime issue %0d: v=%0b x=%0d d=%0d, want 1 %0d 0", i, pe_valid, pe_x, pe_d, i == 1 ? -150 : 22);
            end
         end
      end
      run = 0; cycle();
      checks++;
      if (pe_valid !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL prime stop: v=%0b uf=%0b, want 0 0", pe_valid, underflow);
      end
   endtask

   task automatic test_full();
      run = 0; in_valid = 1;
      for (int i = 0; i < DEPTH; i++) begin
         in_x = $signed($urandom); in_d = $signed($urandom);
         cycle();
      end
      checks++;
      if (in_ready !== 1'b0 || level !== LW'(DEPTH)) begin
         errors++;
         $display("FAIL full: rdy=%0b lvl=%0d, want 0 %0d", in_ready, level, DEPTH);
      end
      in_x = $signed($urandom); in_d = $signed($urandom);
      cycle();
      checks++;
      if (level !== LW'(DEPTH) || level !== m_lvl) begin
         errors++;
         $display("FAIL refuse17: lvl=%0d, want %0d", level, DEPTH);
      end
      in_valid = 0; run = 1;
      cycle(); cycle();
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_before_pop: rdy=%0b, want 0", in_ready);
      end
      cycle();
      checks++;
      if (in_ready !== 1'b1 || level !== LW'(DEPTH-1)) begin
         errors++;
         $display("FAIL full_after_pop: rdy=%0b lvl=%0d, want 1 %0d", in_ready, level, DEPTH-1);
      end
      for (int i = 0; i < 40 && m_q.size() > 0; i++) begin
         cycle();
         checks++;
         if ({pe_valid, pe_x, pe_d, level, in_ready, underflow} !== {m_valid, m_x, m_d, m_lvl, m_rdy, m_uf}) begin
            errors++;
            $display("FAIL drain model i=%0d: dut=%h want=%h", i, {pe_valid, pe_x, pe_d, level, in_ready, underflow}, {m_valid, m_x, m_d, m_lvl, m_rdy, m_uf});
         end
      end
      run = 0; cycle();
   endtask

   task automatic test_ramp();
      int k, issued;
      rst = 1; cycle(); rst = 0;
      k = 1; issued = 0;
      for (int c = 0; c < 600 && issued < 20; c++) begin
         in_valid = k <= 20 && $urandom_range(0, 3) != 0;
         in_x = k; in_d = k + 100;
         run = m_q.size() > 0 && $urandom_range(0, 7) != 0;
         cycle();
         if (m_push) k++;
         checks++;
         if ({pe_valid, pe_x, pe_d, level, in_ready, underflow} !== {m_valid, m_x, m_d, m_lvl, m_rdy, m_uf}) begin
            errors++;
            $display("FAIL ramp model c=%0d: dut=%h want=%h", c, {pe_valid, pe_x, pe_d, level, in_ready, underflow}, {m_valid, m_x, m_d, m_lvl, m_rdy, m_uf});
         end
         if (m_valid) begin
            issued++;
            if (issued > D_DLY) begin
               checks++;
               if (pe_x !== issued || pe_d !== issued - D_DLY + 100) begin
                  errors++;
                  $display("FAIL ramp align: x=%0d d=%0d, want %0d %0d", pe_x, pe_d, issued, issued - D_DLY + 100);
               end
            end
         end
      end
      checks++;
      if (issued != 20) begin
         errors++;
         $display("FAIL ramp budget: issued=%0d, want 20", issued);
      end
      in_valid = 0; run = 0; cycle();
   endtask

   task automatic test_underflow();
      run = 0; in_valid = 1;
      for (int i = 0; i < 2; i++) begin
         in_x = $signed($urandom); in_d = $signed($urandom);
         cycle();
      end
      in_valid = 0; run = 1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         checks++;
         if ({pe_valid, pe_x, pe_d, level, in_ready, underflow} !== {m_valid, m_x, m_d, m_lvl, m_rdy, m_uf}) begin
            errors++;
            $display("FAIL uflow model i=%0d: dut=%h want=%h", i, {pe_valid, pe_x, pe_d, level, in_ready, underflow}, {m_valid, m_x, m_d, m_lvl, m_rdy, m_uf});
         end
      end
      checks++;
`ifdef ZERO_FILL_EN
      if (underflow !== 1'b1 || pe_valid !== 1'b1 || pe_x !== 32'sd0) begin
         errors++;
         $display("FAIL uflow slot: uf=%0b v=%0b x=%0d, want 1 1 0", underflow, pe_valid, pe_x);
      end
`else
      if (underflow !== 1'b1 || pe_valid !== 1'b0) begin
         errors++;
         $display("FAIL uflow slot: uf=%0b v=%0b, want 1 0", underflow, pe_valid);
      end
`endif
      run = 0; cycle(); cycle();
      checks++;
      if (underflow !== 1'b1) begin
         errors++;
         $display("FAIL uflow sticky: uf=%0b, want 1", underflow);
      end
   endtask

   task automatic test_reset_mid();
      run = 0; in_valid = 1;
      for (int i = 0; i < 7; i++) begin
         in_x = $signed($urandom); in_d = $signed($urandom);
         cycle();
      end
      in_valid = 0; run = 1;
      for (int i = 0; i < 4; i++) cycle();
      checks++;
      if (level !== LW'(5) || pe_valid !== 1'b1 || {pe_x, pe_d} !== {m_x, m_d}) begin
         errors++;
         $display("FAIL mid pre: lvl=%0d v=%0b x=%0d d=%0d, want 5 1 %0d %0d", level, pe_valid, pe_x, pe_d, m_x, m_d);
      end
      rst = 1; cycle(); rst = 0;
      checks++;
      if (level !== LW'(0) || pe_valid !== 1'b0 || in_ready !== 1'b1 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL mid rst: lvl=%0d v=%0b rdy=%0b uf=%0b, want 0 0 1 0", level, pe_valid, in_ready, underflow);
      end
      in_valid = 1; in_x = 7; in_d = 9;
      cycle();
      in_valid = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (pe_valid !== 1'b0 || level !== LW'(1) || {pe_valid, level} !== {m_valid, m_lvl}) begin
            errors++;
            $display("FAIL mid idle i=%0d: v=%0b lvl=%0d, want 0 1", i, pe_valid, level);
         end
      end
      run = 0; cycle();
   endtask

   initial begin
      test_reset();
      test_prime();
      test_full();
      test_ramp();
      test_underflow();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
